// File: rtl/apb2axi_rd_collector.sv
// AXI R-channel collector: registers beats toward the read data FIFO and
// tracks per-tag beat counts to report one merged completion per burst.
module apb2axi_rd_collector #(
  parameter  int TAG_W_P  = 4,
  parameter  int DATA_W_P = 32,
  parameter  int LEN_W_P  = 8,
  localparam int NUM_TAGS = 2**TAG_W_P,
  localparam int RDF_W    = TAG_W_P + DATA_W_P + 1
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                ar_issue_valid,
  input  logic [TAG_W_P-1:0]  ar_issue_tag,
  input  logic [LEN_W_P-1:0]  ar_issue_len,
  input  logic                RVALID,
  output logic                RREADY,
  input  logic [TAG_W_P-1:0]  RID,
  input  logic [DATA_W_P-1:0] RDATA,
  input  logic [1:0]          RRESP,
  input  logic                RLAST,
  output logic                rdf_push_valid,
  output logic [RDF_W-1:0]    rdf_push_payload,
  input  logic                rdf_push_ready,
  output logic                cpl_valid,
  output logic [TAG_W_P-1:0]  cpl_tag,
  output logic [1:0]          cpl_resp,
  output logic                cpl_len_err,
  output logic                err_unexp,
  output logic                err_dup_issue,
  output logic [NUM_TAGS-1:0] tag_pending
);

  typedef logic [LEN_W_P:0] cnt_t;

  logic [NUM_TAGS-1:0] pending;
  cnt_t                cnt  [NUM_TAGS];
  logic [LEN_W_P-1:0]  len  [NUM_TAGS];
  logic [1:0]          resp [NUM_TAGS];
  logic                out_v;

  logic acc;
  logic hit;
  logic fin;
  logic iss_ok;
  cnt_t cnt_nxt;
  cnt_t exp_beats;
  logic [1:0] resp_nxt;

  assign RREADY         = !ARESET && (!out_v || rdf_push_ready);
  assign rdf_push_valid = out_v;
  assign tag_pending    = pending;

  // A final beat frees its tag in the same cycle, so a coincident issue
  // to that tag starts the next burst instead of being flagged.
  always_comb begin
    acc       = RVALID && RREADY;
    hit       = acc && pending[RID];
    fin       = hit && RLAST;
    cnt_nxt   = (&cnt[RID]) ? cnt[RID] : cnt[RID] + 1'b1;
    exp_beats = cnt_t'(len[RID]) + 1'b1;
    resp_nxt  = (RRESP > resp[RID]) ? RRESP : resp[RID];
    iss_ok    = ar_issue_valid &&
                (!pending[ar_issue_tag] || (fin && RID == ar_issue_tag));
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      out_v            <= 1'b0;
      rdf_push_payload <= '0;
    end else if (hit) begin
      out_v            <= 1'b1;
      rdf_push_payload <= {RID, RDATA, RLAST};
    end else if (rdf_push_ready) begin
      out_v            <= 1'b0;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      cpl_valid     <= 1'b0;
      cpl_tag       <= '0;
      cpl_resp      <= '0;
      cpl_len_err   <= 1'b0;
      err_unexp     <= 1'b0;
      err_dup_issue <= 1'b0;
    end else begin
      cpl_valid     <= fin;
      cpl_tag       <= fin ? RID : '0;
      cpl_resp      <= fin ? resp_nxt : '0;
      cpl_len_err   <= fin && (cnt_nxt != exp_beats);
      err_unexp     <= acc && !pending[RID];
      err_dup_issue <= ar_issue_valid && !iss_ok;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      pending <= '0;
      for (int i = 0; i < NUM_TAGS; i++) begin
        cnt[i]  <= '0;
        len[i]  <= '0;
        resp[i] <= '0;
      end
    end else begin
      if (hit) begin
        cnt[RID]  <= cnt_nxt;
        resp[RID] <= resp_nxt;
        if (RLAST) pending[RID] <= 1'b0;
      end
      if (iss_ok) begin
        pending[ar_issue_tag] <= 1'b1;
        cnt[ar_issue_tag]     <= '0;
        len[ar_issue_tag]     <= ar_issue_len;
        resp[ar_issue_tag]    <= '0;
      end
    end
  end

endmodule
